// File: rtl/ecg_label_vote_if.sv
// Prediction/vote bus between the upstream classifier and the label-vote stage.
// The master drives the per-beat prediction strobe and label; the slave publishes the vote, alarm and totals.
interface ecg_label_vote_if #(
  parameter int N_CLASS   = 4,
  parameter int CNT_WIDTH = 16
);
  // The prediction is a fire-and-forget strobe: ecg_predict_en_i is a valid
  // with an implied ready of 1, so any label present on a strobe cycle is taken.
  // vote_en_o is likewise a one-cycle valid that nothing can stall.
  logic                         ecg_predict_en_i;
  logic [1:0]                   ecg_predict_label_i;
  logic                         vote_en_o;
  logic [1:0]                   vote_label_o;
  logic                         vote_valid_o;
  logic                         alarm_o;
  logic [N_CLASS*CNT_WIDTH-1:0] class_cnt_o;

  modport master (
    output ecg_predict_en_i, ecg_predict_label_i,
    input  vote_en_o, vote_label_o, vote_valid_o, alarm_o, class_cnt_o
  );

  modport slave (
    input  ecg_predict_en_i, ecg_predict_label_i,
    output vote_en_o, vote_label_o, vote_valid_o, alarm_o, class_cnt_o
  );
endinterface

// File: rtl/ecg_label_vote.sv
// Sliding-window majority vote over classifier labels, with an abnormal-rhythm alarm
// and saturating per-class totals. Start-up labels are discarded before the window fills.
module ecg_label_vote #(
  parameter int N_CLASS   = 4,
  parameter int WIN       = 8,
  parameter int SKIP      = 1,
  parameter int ALARM_TH  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  ecg_label_vote_if.slave    bus,
  output logic [1:0]         dbg_state_o
);
  localparam int HW  = $clog2(WIN + 1);
  localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [HW-1:0]  FILL_LAST = HW'(WIN - 1);
  localparam logic [HW-1:0]  ALARM_LVL = HW'(ALARM_TH);

  typedef enum logic [1:0] {
    ST_SKIP = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam state_t ST_START = (SKIP > 0) ? ST_SKIP : ST_FILL;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SKW-1:0]       r_skip_cnt;
  logic [HW-1:0]        r_fill_cnt;
  logic [1:0]           r_hist [WIN];
  logic [HW-1:0]        r_histo [N_CLASS];
  logic [HW-1:0]        r_abn;
  logic [CNT_WIDTH-1:0] r_cnt [N_CLASS];
  logic                 r_vote_en;
  logic [1:0]           r_vote_label;
  logic                 r_vote_valid;
  logic                 r_alarm;

  logic                         w_strobe;
  logic                         w_accept;
  logic                         w_skip_inc;
  logic                         w_evict_en;
  logic                         w_full_after;
  logic [1:0]                   w_label;
  logic [1:0]                   w_evict;
  logic [HW-1:0]                w_histo_nxt [N_CLASS];
  logic [HW-1:0]                w_abn_nxt;
  logic [HW-1:0]                w_max;
  logic [1:0]                   w_best;
  logic [1:0]                   w_vote;
  logic [N_CLASS*CNT_WIDTH-1:0] w_cnt_flat;

  // Clear dominates a coincident strobe, so the label is simply never seen.
  assign w_strobe = bus.ecg_predict_en_i && !clear_i;
  assign w_label  = bus.ecg_predict_label_i;
  assign w_evict  = r_hist[WIN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_state <= ST_START;
    else if (clear_i) r_state <= ST_START;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SKIP: if (w_strobe && r_skip_cnt == SKIP_LAST) w_state_nxt = ST_FILL;
      ST_FILL: if (w_strobe && r_fill_cnt == FILL_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_START;
    endcase
  end

  always_comb begin
    w_accept     = 1'b0;
    w_skip_inc   = 1'b0;
    w_evict_en   = 1'b0;
    w_full_after = 1'b0;
    case (r_state)
      ST_SKIP: w_skip_inc = w_strobe;
      ST_FILL: begin
        w_accept     = w_strobe;
        w_full_after = w_strobe && (r_fill_cnt == FILL_LAST);
      end
      ST_RUN: begin
        w_accept     = w_strobe;
        w_evict_en   = w_strobe;
        w_full_after = w_strobe;
      end
      default: ;
    endcase
  end

  // Same class in and out nets to zero because both adjustments apply to one entry.
  always_comb begin
    for (int k = 0; k < N_CLASS; k++) begin
      w_histo_nxt[k] = r_histo[k];
      if (w_accept && w_label == 2'(k))   w_histo_nxt[k] = w_histo_nxt[k] + HW'(1);
      if (w_evict_en && w_evict == 2'(k)) w_histo_nxt[k] = w_histo_nxt[k] - HW'(1);
    end
    w_abn_nxt = r_abn + HW'(w_accept && w_label != 2'd0)
                      - HW'(w_evict_en && w_evict != 2'd0);
  end

  // Strict '>' keeps the lowest tied index; the previous vote overrides it when tied.
  always_comb begin
    w_max  = '0;
    w_best = 2'd0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (w_histo_nxt[k] > w_max) begin
        w_max  = w_histo_nxt[k];
        w_best = 2'(k);
      end
    end
    w_vote = (w_histo_nxt[r_vote_label] == w_max) ? r_vote_label : w_best;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear_i) begin
      r_skip_cnt   <= '0;
      r_fill_cnt   <= '0;
      r_abn        <= '0;
      r_vote_en    <= 1'b0;
      r_vote_label <= 2'd0;
      r_vote_valid <= 1'b0;
      r_alarm      <= 1'b0;
      for (int i = 0; i < WIN; i++)     r_hist[i]  <= 2'd0;
      for (int k = 0; k < N_CLASS; k++) r_histo[k] <= '0;
      for (int k = 0; k < N_CLASS; k++) r_cnt[k]   <= '0;
    end else begin
      if (w_skip_inc) r_skip_cnt <= r_skip_cnt + SKW'(1);
      if (w_accept && r_state == ST_FILL) r_fill_cnt <= r_fill_cnt + HW'(1);
      if (w_accept) begin
        for (int i = WIN - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= w_label;
        r_abn     <= w_abn_nxt;
        for (int k = 0; k < N_CLASS; k++) begin
          r_histo[k] <= w_histo_nxt[k];
          if (w_label == 2'(k) && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + CNT_WIDTH'(1);
        end
      end
      r_vote_en <= w_full_after;
      if (w_full_after) begin
        r_vote_label <= w_vote;
        r_alarm      <= (w_abn_nxt >= ALARM_LVL);
        r_vote_valid <= 1'b1;
      end
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_evict_en |-> (r_histo[w_evict] != '0) && (w_evict == 2'd0 || r_abn != '0));

  always_comb begin
    w_cnt_flat = '0;
    for (int k = 0; k < N_CLASS; k++) w_cnt_flat[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
  end

  assign bus.vote_en_o    = r_vote_en;
  assign bus.vote_label_o = r_vote_label;
  assign bus.vote_valid_o = r_vote_valid;
  assign bus.alarm_o      = r_alarm;
  assign bus.class_cnt_o  = w_cnt_flat;
  assign dbg_state_o      = r_state;
endmodule
